// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel prescaler, x/y position,
// registered sync/active-video flags and line/frame strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 4,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          pix_tick,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_end,
    output logic          frame_end
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [HW-1:0] X_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] Y_LAST = VW'(V_TOTAL - 1);

    // One extra bit so sync end == total still fits when a porch is 0.
    localparam logic [HW:0] HA_W     = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] HS_START = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0] HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0] VA_W     = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] VS_START = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0] VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [PW-1:0] p;
    logic [HW-1:0] x_nxt;
    logic [VW-1:0] y_nxt;
    logic          x_last;
    logic          y_last;
    logic          hs_nxt;
    logic          vs_nxt;
    logic          vo_nxt;

    assign pix_tick  = enable && (p == P_LAST);
    assign x_last    = (x == X_LAST);
    assign y_last    = (y == Y_LAST);
    assign line_end  = pix_tick && x_last;
    assign frame_end = line_end && y_last;

    always_comb begin
        x_nxt = x + HW'(1);
        y_nxt = y;
        if (x_last) begin
            x_nxt = '0;
            y_nxt = y_last ? '0 : y + VW'(1);
        end
    end

    // Flags decode the position being loaded so they track x/y exactly.
    always_comb begin
        hs_nxt = !HS_POL;
        vs_nxt = !VS_POL;
        vo_nxt = ({1'b0, x_nxt} < HA_W) && ({1'b0, y_nxt} < VA_W);
        if (({1'b0, x_nxt} >= HS_START) && ({1'b0, x_nxt} < HS_END))
            hs_nxt = HS_POL;
        if (({1'b0, y_nxt} >= VS_START) && ({1'b0, y_nxt} < VS_END))
            vs_nxt = VS_POL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p <= '0;
        end else if (enable) begin
            p <= pix_tick ? '0 : p + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            hsync    <= !HS_POL;
            vsync    <= !VS_POL;
            video_on <= 1'b1;
        end else if (pix_tick) begin
            x        <= x_nxt;
            y        <= y_nxt;
            hsync    <= hs_nxt;
            vsync    <= vs_nxt;
            video_on <= vo_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster geometry, two parameter sets,
// directed table, freeze/reset sequences and random enable vs a model.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 5, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int DIV_A = 3;
    localparam int DIV_B = 1;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    logic       tick_a, hs_a, vs_a, vo_a, le_a, fe_a;
    logic [3:0] x_a, y_a;
    logic       tick_b, hs_b, vs_b, vo_b, le_b, fe_b;
    logic [3:0] x_b, y_b;

    int n_chk  = 0;
    int n_fail = 0;
    int ec_a   = 0;
    int ec_b   = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(DIV_A)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .pix_tick(tick_a), .x(x_a), .y(y_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
        .line_end(le_a), .frame_end(fe_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(DIV_B)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .pix_tick(tick_b), .x(x_b), .y(y_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
        .line_end(le_b), .frame_end(fe_b)
    );

    typedef struct {
        int x, y;
        bit hs, vs, vo, tk, le, fe;
    } exp_t;

    typedef struct {
        int adv;
        int x, y;
        bit hs, vs, vo, tk, le, fe;
    } vec_t;

    // Cumulative enabled-clock steps for dut_a (CLK_DIV=3, active-low sync).
    vec_t tbl[13] = '{
        '{  0,  0, 0, 1, 1, 1, 0, 0, 0},
        '{  2,  0, 0, 1, 1, 1, 1, 0, 0},
        '{  1,  1, 0, 1, 1, 1, 0, 0, 0},
        '{ 18,  7, 0, 1, 1, 1, 0, 0, 0},
        '{  3,  8, 0, 1, 1, 0, 0, 0, 0},
        '{  6, 10, 0, 0, 1, 0, 0, 0, 0},
        '{  9, 13, 0, 1, 1, 0, 0, 0, 0},
        '{  5, 14, 0, 1, 1, 0, 1, 1, 0},
        '{  1,  0, 1, 1, 1, 1, 0, 0, 0},
        '{225,  0, 6, 1, 0, 0, 0, 0, 0},
        '{ 90,  0, 8, 1, 1, 0, 0, 0, 0},
        '{ 44, 14, 8, 1, 1, 0, 1, 1, 1},
        '{  1,  0, 0, 1, 1, 1, 0, 0, 0}
    };

    // Position is a pure function of enabled clocks since reset.
    function automatic exp_t model(int ec, bit en, int div,
                                   bit hp, bit vp);
        exp_t e;
        int k;
        k    = ec / div;
        e.x  = k % HT;
        e.y  = (k / HT) % VT;
        e.tk = en && ((ec % div) == div - 1);
        e.le = e.tk && (e.x == HT - 1);
        e.fe = e.le && (e.y == VT - 1);
        e.vo = (e.x < HA) && (e.y < VA);
        e.hs = (e.x >= HA + HF && e.x < HA + HF + HS) ? hp : !hp;
        e.vs = (e.y >= VA + VF && e.y < VA + VF + VS) ? vp : !vp;
        return e;
    endfunction

    function automatic void chk(string nm, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, req, $time);
        end
    endfunction

    function automatic void chk_a(string pf, exp_t e);
        chk({pf, ".x"},    int'(x_a),  e.x);
        chk({pf, ".y"},    int'(y_a),  e.y);
        chk({pf, ".hs"},   int'(hs_a), int'(e.hs));
        chk({pf, ".vs"},   int'(vs_a), int'(e.vs));
        chk({pf, ".vo"},   int'(vo_a), int'(e.vo));
        chk({pf, ".tick"}, int'(tick_a), int'(e.tk));
        chk({pf, ".le"},   int'(le_a), int'(e.le));
        chk({pf, ".fe"},   int'(fe_a), int'(e.fe));
    endfunction

    function automatic void chk_b(string pf, exp_t e);
        chk({pf, ".x"},    int'(x_b),  e.x);
        chk({pf, ".y"},    int'(y_b),  e.y);
        chk({pf, ".hs"},   int'(hs_b), int'(e.hs));
        chk({pf, ".vs"},   int'(vs_b), int'(e.vs));
        chk({pf, ".vo"},   int'(vo_b), int'(e.vo));
        chk({pf, ".tick"}, int'(tick_b), int'(e.tk));
        chk({pf, ".le"},   int'(le_b), int'(e.le));
        chk({pf, ".fe"},   int'(fe_b), int'(e.fe));
    endfunction

    // Called at a negedge; checks both DUTs then crosses one posedge.
    task automatic step(input bit en);
        enable = en;
        #1;
        chk_a("a", model(ec_a, en, DIV_A, 1'b0, 1'b0));
        chk_b("b", model(ec_b, en, DIV_B, 1'b1, 1'b1));
        @(posedge clk);
        if (!reset && en) begin
            ec_a++;
            ec_b++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ec_a  = 0;
        ec_b  = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            repeat (tbl[i].adv) step(1'b1);
            enable = 1'b1;
            #1;
            chk_a($sformatf("tbl%0d", i), '{tbl[i].x, tbl[i].y,
                  tbl[i].hs, tbl[i].vs, tbl[i].vo,
                  tbl[i].tk, tbl[i].le, tbl[i].fe});
        end
        @(negedge clk);

        // Freeze mid-prescale at x=5, p=1 for 37 clocks.
        do_reset();
        repeat (16) step(1'b1);
        repeat (37) begin
            enable = 1'b0;
            #1;
            chk("frz.tick", int'(tick_a), 0);
            chk("frz.x", int'(x_a), 5);
            chk("frz.y", int'(y_a), 0);
            chk("frz.vo", int'(vo_a), 1);
            @(negedge clk);
        end
        step(1'b1);
        enable = 1'b1;
        #1;
        chk("res.tick", int'(tick_a), 1);
        chk("res.x", int'(x_a), 5);
        @(negedge clk);
        ec_a = 18;
        ec_b = 18;
        #1;
        chk("res.x1", int'(x_a), 6);
        @(negedge clk);

        // Async reset with both syncs active, no clock edge in between.
        do_reset();
        repeat (304) step(1'b1);
        enable = 1'b1;
        #1;
        chk("pre.x", int'(x_a), 11);
        chk("pre.y", int'(y_a), 6);
        chk("pre.hs", int'(hs_a), 0);
        chk("pre.vs", int'(vs_a), 0);
        #1;
        reset = 1'b1;
        #1;
        chk("rst.x", int'(x_a), 0);
        chk("rst.y", int'(y_a), 0);
        chk("rst.hs", int'(hs_a), 1);
        chk("rst.vs", int'(vs_a), 1);
        chk("rst.vo", int'(vo_a), 1);
        chk("rst.tick", int'(tick_a), 0);
        chk("rst.hs_b", int'(hs_b), 0);
        chk("rst.vs_b", int'(vs_b), 0);
        @(negedge clk);
        do_reset();

        repeat (3000) begin
            if ($urandom_range(0, 399) == 0)
                do_reset();
            step($urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It replaces separate free-running horizontal and vertical counters with one block that owns the pixel-rate prescaler, the 2-D pixel position, the sync pulses and the active-video flag. It sits between the system clock domain and the pixel/colour pipeline. Defaults give 640x480 @ 60 Hz from a 100 MHz clock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- CLK_DIV, 4, clk cycles per pixel, >= 1
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  advance timing; low freezes all state
- pix_tick  out  1  one-clk strobe at each pixel advance
- x  out  HW  horizontal position, 0..H_TOTAL-1
- y  out  VW  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- video_on  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- line_end  out  1  strobe on last pixel tick of a line
- frame_end  out  1  strobe on last pixel tick of a frame

## Operation
- Prescaler p counts 0..CLK_DIV-1 while enable=1, then wraps to 0. pix_tick = enable && (p == CLK_DIV-1), combinational. CLK_DIV=1: pix_tick = enable.
- On pix_tick: if x == H_TOTAL-1, x <= 0 and y advances; otherwise x <= x+1.
- y advance: if y == V_TOTAL-1, y <= 0; otherwise y <= y+1.
- x and y never exceed H_TOTAL-1 / V_TOTAL-1.
- hsync is active when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751). Otherwise it is at the inactive level (!HS_POL).
- vsync is active when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491). Otherwise it is at the inactive level (!VS_POL).
- hsync, vsync and video_on are registered. Each is loaded on the same edge as x/y with the decode of the next x/y, so it always matches the current x/y.
- line_end = pix_tick && x == H_TOTAL-1. frame_end = line_end && y == V_TOTAL-1. Both are combinational.
- enable=0: p, x, y and all registered outputs hold. Strobes are 0.

## Timing
- Reset (async assert, sync-to-clk release is the integrator's job) sets p=0, x=0, y=0, hsync=!HS_POL, vsync=!VS_POL, video_on=1. Strobes read 0 while p=0 and CLK_DIV>1.
- Reset mid-frame returns to exactly this state immediately. The first pix_tick after release occurs CLK_DIV cycles later with enable held high.
- x changes one clk after pix_tick. A line lasts H_TOTAL*CLK_DIV clk; a frame lasts H_TOTAL*V_TOTAL*CLK_DIV clk (default 1,680,000).
- Pixel-data latency: the colour pipeline samples x/y/video_on when pix_tick is high; values are stable for the full CLK_DIV period.
- Simultaneous x wrap and y wrap occur on the same edge; frame_end and line_end are both high on that pix_tick.

## Test plan
- Reset asserted, then released with enable=1 -> x=0, y=0, video_on=1, hsync=vsync=1. First pix_tick on the 4th clk; x=1 one clk later.
- Run one line -> hsync low for exactly 96 pixel ticks starting at x=656; video_on falls at x=640; line_end high once at x=799, then x=0, y=1.
- Run a full frame -> vsync low for y=490..491 only; frame_end pulses exactly once per 1,680,000 clk; y wraps 524->0.
- Drop enable for 37 clk mid-line at x=300 -> x, y, p and outputs frozen with no pix_tick; resumes at x=301 after the remaining prescaler count.
- Assert reset at x=700, y=491 (hsync and vsync active) -> all outputs return to reset values without a clock edge.
- Parameters HS_POL=1, VS_POL=1, CLK_DIV=1 -> pix_tick high every clk, sync pulses active-high at the same positions, frame = 420,000 clk.
